// File: rtl/byte_deser.sv
// Framed serial-to-parallel deserialiser feeding a downstream holding register (D bus + active-low EN).
// Define BYTE_DESER_PARITY_EN to extend each frame with an even-parity bit that gates the load strobe.
module byte_deser #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1,
    parameter int TIMEOUT   = 16
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             SI,
    input  logic             SV,
    input  logic             FS,
    output logic [WIDTH-1:0] D,
    output logic             EN,
    output logic             BUSY,
    output logic             ERR
);

    localparam int CW = $clog2(WIDTH + 2);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0]    tocnt_q, tocnt_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             en_q, en_d;
    logic             busy_q;
    logic             err_q, err_d;

    // WIDTH is assumed to be at least 2.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base, input logic b);
        if (MSB_FIRST != 0) begin
            return {base[WIDTH-2:0], b};
        end
        return {b, base[WIDTH-1:1]};
    endfunction

    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            tocnt_q  <= '0;
            d_q      <= '0;
            en_q     <= 1'b1;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            tocnt_q  <= tocnt_d;
            d_q      <= d_d;
            en_q     <= en_d;
            busy_q   <= (state_d == SHIFT);
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        tocnt_d  = tocnt_q;
        d_d      = d_q;
        en_d     = 1'b1;
        err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                tocnt_d = '0;
                if (SV && FS) begin
                    shreg_d  = shift_in('0, SI);
                    bitcnt_d = CW'(1);
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (SV && FS) begin
                    // Truncated frame: drop the partial word and restart on this bit.
                    err_d    = 1'b1;
                    shreg_d  = shift_in('0, SI);
                    bitcnt_d = CW'(1);
                    tocnt_d  = '0;
                end else if (SV) begin
                    tocnt_d = '0;
`ifdef BYTE_DESER_PARITY_EN
                    if (bitcnt_q == CW'(WIDTH)) begin
                        state_d  = IDLE;
                        bitcnt_d = '0;
                        if (SI == ^shreg_q) begin
                            d_d  = shreg_q;
                            en_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        shreg_d  = shift_in(shreg_q, SI);
                        bitcnt_d = bitcnt_q + CW'(1);
                    end
`else
                    if (bitcnt_q == CW'(WIDTH - 1)) begin
                        d_d      = shift_in(shreg_q, SI);
                        en_d     = 1'b0;
                        state_d  = IDLE;
                        bitcnt_d = '0;
                    end else begin
                        shreg_d  = shift_in(shreg_q, SI);
                        bitcnt_d = bitcnt_q + CW'(1);
                    end
`endif
                end else if (TIMEOUT != 0) begin
                    if (tocnt_q == TW'(TIMEOUT - 1)) begin
                        err_d    = 1'b1;
                        state_d  = IDLE;
                        bitcnt_d = '0;
                        tocnt_d  = '0;
                    end else begin
                        tocnt_d = tocnt_q + TW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign D    = d_q;
    assign EN   = en_q;
    assign BUSY = busy_q;
    assign ERR  = err_q;

endmodule
